bldc_six_step_ctrl: RTL

//   Parametrised six-step (trapezoidal) BLDC commutation controller with FSM, duty ramp, centre-free

---
 rtl/bldc_pkg.sv | 50 +++++
 rtl/bldc_pwm_gen.sv | 23 ++
 rtl/bldc_six_step_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/bldc_pkg.sv
// Shared definitions for the six-step BLDC controller: FSM encoding, fault codes
// and the hall/direction to gate-pattern decode.
package bldc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RAMP  = 2'b01,
        ST_RUN   = 2'b10,
        ST_FAULT = 2'b11
    } state_e;

    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_HALL  = 2'b01;
    localparam logic [1:0] FC_STALL = 2'b10;
    localparam logic [1:0] FC_EXT   = 2'b11;

    typedef struct packed {
        logic [2:0] hi;
        logic [2:0] lo;
    } gate_pat_t;

    function automatic logic hall_invalid(input logic [2:0] h);
        return (h == 3'b000) || (h == 3'b111);
    endfunction

    // Bit order of hi/lo is {C,B,A}; reverse rotation swaps the driven pair.
    function automatic gate_pat_t sector_decode(input logic [2:0] hall, input logic dir);
        gate_pat_t  p;
        logic [2:0] src;
        logic [2:0] snk;
        case (hall)
            3'b101:  begin src = 3'b001; snk = 3'b010; end
            3'b100:  begin src = 3'b001; snk = 3'b100; end
            3'b110:  begin src = 3'b010; snk = 3'b100; end
            3'b010:  begin src = 3'b010; snk = 3'b001; end
            3'b011:  begin src = 3'b100; snk = 3'b001; end
            3'b001:  begin src = 3'b100; snk = 3'b010; end
            default: begin src = 3'b000; snk = 3'b000; end
        endcase
        if (dir) begin
            p.hi = snk;
            p.lo = src;
        end else begin
            p.hi = src;
            p.lo = snk;
        end
        return p;
    endfunction

endpackage

// File: rtl/bldc_pwm_gen.sv
// Free-running edge-aligned PWM: on while the carrier is below the duty value.
module bldc_pwm_gen #(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PWM_W-1:0] duty_i,
    output logic             pwm_on_o
);

    logic [PWM_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign pwm_on_o = (cnt_q < duty_i);

endmodule

// File: rtl/bldc_six_step_ctrl.sv
// Six-step BLDC commutation controller: run FSM, duty ramp, commutation dead-time,
// hall stall detection and first-cause fault latching.
module bldc_six_step_ctrl
    import bldc_pkg::*;
#(
    parameter int PWM_W    = 8,
    parameter int RAMP_DIV = 16,
    parameter int DEAD_T   = 4,
    parameter int STALL_W  = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             dir,
    input  logic             fault_in,
    input  logic             clear_fault,
    input  logic [2:0]       hall,
    input  logic [PWM_W-1:0] speed_set,
    output logic [2:0]       gate_hi,
    output logic [2:0]       gate_lo,
    output logic [PWM_W-1:0] duty,
    output logic             motor_enable,
    output logic [1:0]       state,
    output logic [1:0]       fault_code
);

    localparam int DIV_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DEAD_W = $clog2(DEAD_T + 1);

    state_e             state_q, state_d;
    logic [1:0]         cause_d;
    logic [1:0]         fault_code_q;
    logic [PWM_W-1:0]   duty_q, duty_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [2:0]         hall_q, cur_hall_q;
    logic               dir_q, cur_dir_q;
    logic [DEAD_W-1:0]  dead_q;
    logic [STALL_W-1:0] stall_q;
    logic               run_q, run_d;
    logic               ramp_tick;
    logic               hall_chg, comm_chg, stall_max;
    logic               pwm_on;
    gate_pat_t          pat;

    assign run_q     = (state_q == ST_RAMP) || (state_q == ST_RUN);
    assign run_d     = (state_d == ST_RAMP) || (state_d == ST_RUN);
    assign ramp_tick = (div_q == DIV_W'(RAMP_DIV - 1));
    assign hall_chg  = (hall_q != cur_hall_q);
    assign comm_chg  = hall_chg || (dir_q != cur_dir_q);
    assign stall_max = (stall_q == '1);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state, in fault-priority order
    always_comb begin
        state_d = state_q;
        cause_d = FC_NONE;
        case (state_q)
            ST_IDLE: begin
                if (fault_in) begin
                    state_d = ST_FAULT;
                    cause_d = FC_EXT;
                end else if (enable) begin
                    state_d = ST_RAMP;
                end
            end
            ST_RAMP, ST_RUN: begin
                if (fault_in) begin
                    state_d = ST_FAULT;
                    cause_d = FC_EXT;
                end else if (hall_invalid(hall_q)) begin
                    state_d = ST_FAULT;
                    cause_d = FC_HALL;
                end else if (stall_max) begin
                    state_d = ST_FAULT;
                    cause_d = FC_STALL;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end else if ((state_q == ST_RAMP) && (duty_q == speed_set)) begin
                    state_d = ST_RUN;
                end
            end
            ST_FAULT: begin
                if (clear_fault && !fault_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs; gates stay off outside RAMP/RUN and during dead-time
    always_comb begin
        pat          = sector_decode(cur_hall_q, cur_dir_q);
        motor_enable = run_q;
        gate_hi      = '0;
        gate_lo      = '0;
        if (run_q && (dead_q == '0)) begin
            gate_hi = pat.hi & {3{pwm_on}};
            gate_lo = pat.lo;
        end
    end

    // Duty ramp; leaving RAMP/RUN drops duty on the same edge
    always_comb begin
        duty_d = duty_q;
        div_d  = '0;
        if (!run_d) begin
            duty_d = '0;
        end else if (run_q) begin
            div_d = ramp_tick ? '0 : div_q + 1'b1;
            if (ramp_tick) begin
                if (duty_q < speed_set) begin
                    duty_d = duty_q + 1'b1;
                end else if (duty_q > speed_set) begin
                    duty_d = duty_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            duty_q       <= '0;
            div_q        <= '0;
            fault_code_q <= FC_NONE;
        end else begin
            duty_q <= duty_d;
            div_q  <= div_d;
            if ((state_q != ST_FAULT) && (state_d == ST_FAULT)) begin
                fault_code_q <= cause_d;
            end else if ((state_q == ST_FAULT) && (state_d == ST_IDLE)) begin
                fault_code_q <= FC_NONE;
            end
        end
    end

    // Commutation tracking and stall timer; a change mid dead-time restarts it
    always_ff @(posedge clk) begin
        if (reset) begin
            hall_q     <= '0;
            dir_q      <= 1'b0;
            cur_hall_q <= '0;
            cur_dir_q  <= 1'b0;
            dead_q     <= '0;
            stall_q    <= '0;
        end else begin
            hall_q <= hall;
            dir_q  <= dir;
            if (comm_chg) begin
                cur_hall_q <= hall_q;
                cur_dir_q  <= dir_q;
                dead_q     <= DEAD_W'(DEAD_T);
            end else if (dead_q != '0) begin
                dead_q <= dead_q - 1'b1;
            end
            if (!run_q || hall_chg) begin
                stall_q <= '0;
            end else if (!stall_max) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    bldc_pwm_gen #(
        .PWM_W(PWM_W)
    ) u_pwm (
        .clk     (clk),
        .reset   (reset),
        .duty_i  (duty_q),
        .pwm_on_o(pwm_on)
    );

    assign state      = state_q;
    assign duty       = duty_q;
    assign fault_code = fault_code_q;

    a_no_shoot_through: assert property (@(posedge clk) disable iff (reset)
        (gate_hi & gate_lo) == 3'b000);

endmodule
